common_word_packer_w_valid: RTL and testbench

- Assembles a stream of narrow, valid-qualified words into full-width GHASH blocks.
- Zero-pads the final partial block of each frame.
- Emits each block with a one-cycle valid pulse. This pulse drives the i_valid of the fixed delay line and the GHASH multiplier stage directly downstream.
- The first word received in a block occupies the MSBs, giving GCM big-endian block order.

---
 rtl/common_word_packer_w_valid.sv | 124 ++++++++++++
 tb/tb_common_word_packer_w_valid.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/common_word_packer_w_valid.sv
// -----------------------------------------------------------------------------
// common_word_packer_w_valid
//
// Packs a stream of narrow, valid-qualified words into full-width blocks for a
// GHASH datapath. The first word of a block lands in the MSBs (GCM big-endian
// block order). A frame's final partial block is zero-padded. Each finished
// block is presented with a single-cycle o_valid pulse one clock after the
// completing word is accepted. No backpressure: one word per cycle.
//
// Ports
//   clock     : rising-edge clock for all logic
//   i_reset   : asynchronous active-high reset
//   i_data    : input word (NB_WORD bits)
//   i_valid   : i_data valid this cycle
//   i_sof     : start of frame (qualified by i_valid)
//   i_eof     : last word of frame (qualified by i_valid)
//   o_data    : assembled block (NB_WORD*N_WORDS bits), held between pulses
//   o_valid   : one-cycle pulse, o_data carries a new block
//   o_last    : the block in o_data closes the frame
//   o_nwords  : number of real words in o_data (1..N_WORDS)
//   o_drop    : one-cycle pulse when an SOF discards a partial block
// -----------------------------------------------------------------------------
module common_word_packer_w_valid #(
    parameter int NB_WORD   = 32,
    parameter int N_WORDS   = 4,
    parameter int NB_NWORDS = 3
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic [NB_WORD-1:0]           i_data,
    input  logic                         i_valid,
    input  logic                         i_sof,
    input  logic                         i_eof,
    output logic [NB_WORD*N_WORDS-1:0]   o_data,
    output logic                         o_valid,
    output logic                         o_last,
    output logic [NB_NWORDS-1:0]         o_nwords,
    output logic                         o_drop
);

    localparam int NB_DATA = NB_WORD * N_WORDS;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    // State and output registers
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [NB_DATA-1:0]   buf_q,    buf_d;
    logic [NB_DATA-1:0]   data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 last_q,   last_d;
    logic [NB_NWORDS-1:0] nwords_q, nwords_d;
    logic                 drop_q,   drop_d;

    // Write position and buffer base: an SOF restarts the block at slot 0
    // from an empty buffer, discarding anything collected so far.
    logic [CNT_W-1:0]   wpos;
    logic [NB_DATA-1:0] base;
    logic [NB_DATA-1:0] merged;
    logic               complete;

    assign wpos     = i_sof ? '0 : cnt_q;
    assign base     = i_sof ? '0 : buf_q;
    assign complete = i_valid && ((wpos == CNT_W'(N_WORDS - 1)) || i_eof);

    // Buffer with the incoming word dropped into its slot; slot 0 is the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi = gi + 1) begin : g_slot
            assign merged[NB_DATA-1-gi*NB_WORD -: NB_WORD] =
                (wpos == CNT_W'(gi)) ? i_data : base[NB_DATA-1-gi*NB_WORD -: NB_WORD];
        end
    endgenerate

    always_comb begin
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        last_d   = last_q;
        nwords_d = nwords_q;
        drop_d   = 1'b0;
        if (i_valid) begin
            drop_d = i_sof && (cnt_q != '0);
            if (complete) begin
                data_d   = merged;
                valid_d  = 1'b1;
                last_d   = i_eof;
                nwords_d = NB_NWORDS'(wpos) + NB_NWORDS'(1);
                // Clearing here is what zero-pads the next block's unused slots.
                cnt_d    = '0;
                buf_d    = '0;
            end else begin
                cnt_d = wpos + CNT_W'(1);
                buf_d = merged;
            end
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            buf_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            nwords_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            nwords_q <= nwords_d;
            drop_q   <= drop_d;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_last   = last_q;
    assign o_nwords = nwords_q;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_common_word_packer_w_valid.sv
module tb_common_word_packer_w_valid;

    localparam int NB_WORD   = 32;
    localparam int N_WORDS   = 4;
    localparam int NB_NWORDS = 3;
    localparam int NB_DATA   = NB_WORD * N_WORDS;

    logic                 clock = 1'b0;
    logic                 i_reset;
    logic [NB_WORD-1:0]   i_data;
    logic                 i_valid;
    logic                 i_sof;
    logic                 i_eof;
    logic [NB_DATA-1:0]   o_data;
    logic                 o_valid;
    logic                 o_last;
    logic [NB_NWORDS-1:0] o_nwords;
    logic                 o_drop;

    common_word_packer_w_valid #(
        .NB_WORD  (NB_WORD),
        .N_WORDS  (N_WORDS),
        .NB_NWORDS(NB_NWORDS)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_eof   (i_eof),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_nwords(o_nwords),
        .o_drop  (o_drop)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [NB_DATA-1:0]   data;
        logic                 last;
        logic [NB_NWORDS-1:0] nwords;
        int                   cyc;
    } blk_t;

    blk_t               exp_q[$];
    int                 drop_q[$];
    logic [NB_WORD-1:0] part_q[$];   // words of the block being assembled

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [NB_DATA-1:0]   hold_data   = '0;
    logic                 hold_last   = 1'b0;
    logic [NB_NWORDS-1:0] hold_nwords = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NB_DATA-1:0] act, input logic [NB_DATA-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frames are lists of words; a block closes when it
    // holds N_WORDS words or the word carries EOF.
    task automatic model_accept(input logic s, input logic e, input logic [NB_WORD-1:0] d);
        blk_t b;
        if (s) begin
            if (part_q.size() != 0) drop_q.push_back(cyc + 1);
            part_q.delete();
        end
        part_q.push_back(d);
        if (part_q.size() == N_WORDS || e) begin
            b.data = '0;
            for (int i = 0; i < part_q.size(); i++)
                b.data[NB_DATA-1-i*NB_WORD -: NB_WORD] = part_q[i];
            b.last   = e;
            b.nwords = NB_NWORDS'(part_q.size());
            b.cyc    = cyc + 1;
            exp_q.push_back(b);
            $display("[TB] cyc %0d expect block %h last=%0d nwords=%0d", b.cyc, b.data, b.last, b.nwords);
            part_q.delete();
        end
    endtask

    task automatic send(input logic v, input logic s, input logic e, input logic [NB_WORD-1:0] d);
        i_valid = v;
        i_sof   = s;
        i_eof   = e;
        i_data  = d;
        if (v) model_accept(s, e, d);
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // Monitor: checks every presented block and drop pulse against the
    // scoreboard, and checks output hold between pulses.
    always @(negedge clock) begin
        blk_t e;
        int   dc;
        if (o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: cyc %0d got data %h, no block expected", cyc, o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e.data || o_last !== e.last || o_nwords !== e.nwords || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL block: got %h last=%0d nw=%0d cyc=%0d expected %h last=%0d nw=%0d cyc=%0d",
                             o_data, o_last, o_nwords, cyc, e.data, e.last, e.nwords, e.cyc);
                end else begin
                    $display("[TB] cyc %0d block ok %h last=%0d nwords=%0d", cyc, o_data, o_last, o_nwords);
                end
                hold_data   = e.data;
                hold_last   = e.last;
                hold_nwords = e.nwords;
            end
        end else begin
            n_tests++;
            if (o_data !== hold_data || o_last !== hold_last || o_nwords !== hold_nwords) begin
                n_fail++;
                $display("FAIL hold: cyc %0d got %h/%0d/%0d expected %h/%0d/%0d",
                         cyc, o_data, o_last, o_nwords, hold_data, hold_last, hold_nwords);
            end
        end
        if (o_drop) begin
            n_tests++;
            if (drop_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_drop: cyc %0d got o_drop=1 expected 0", cyc);
            end else begin
                dc = drop_q.pop_front();
                if (dc != cyc) begin
                    n_fail++;
                    $display("FAIL drop_cycle: got cyc %0d expected cyc %0d", cyc, dc);
                end else begin
                    $display("[TB] cyc %0d drop ok", cyc);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"},   o_data, '0);
        chk({tag, "_valid"},  NB_DATA'(o_valid), '0);
        chk({tag, "_last"},   NB_DATA'(o_last), '0);
        chk({tag, "_nwords"}, NB_DATA'(o_nwords), '0);
        chk({tag, "_drop"},   NB_DATA'(o_drop), '0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eof   = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        i_reset = 1'b0;
        idle(2);

        // Full 4-word frame
        send(1, 1, 0, 32'h11111111);
        send(1, 0, 0, 32'h22222222);
        send(1, 0, 0, 32'h33333333);
        send(1, 0, 1, 32'h44444444);
        idle(2);

        // Partial frame with gaps, then a full frame that must carry no residue
        send(1, 1, 0, 32'hAAAA0001);
        send(1, 0, 0, 32'hBBBB0002);
        idle(2);
        send(1, 0, 1, 32'hCCCC0003);
        send(1, 1, 0, 32'hD0000001);
        send(1, 0, 0, 32'hD0000002);
        send(1, 0, 0, 32'hD0000003);
        send(1, 0, 1, 32'hD0000004);
        idle(2);

        // Early SOF discards a 2-word partial block
        send(1, 1, 0, 32'hE0000001);
        send(1, 0, 0, 32'hE0000002);
        send(1, 1, 0, 32'hF0000000);
        send(1, 0, 0, 32'hF0000001);
        send(1, 0, 0, 32'hF0000002);
        send(1, 0, 0, 32'hF0000003);
        idle(2);

        // 9 back-to-back words, EOF on the 9th
        for (int i = 1; i <= 9; i++)
            send(1, i == 1, i == 9, 32'h90000000 + 32'(i));
        idle(2);

        // Single-word frame
        send(1, 1, 1, 32'h5A5A5A5A);
        idle(2);

        // Asynchronous reset mid-block
        send(1, 1, 0, 32'h12340001);
        send(1, 0, 0, 32'h12340002);
        #2;
        i_reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        part_q.delete();
        hold_data   = '0;
        hold_last   = 1'b0;
        hold_nwords = '0;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        send(1, 0, 0, 32'h77770001);
        send(1, 0, 0, 32'h77770002);
        send(1, 0, 0, 32'h77770003);
        send(1, 0, 1, 32'h77770004);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic v, s, e;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 19) < 3);
            send(v, s, e, $urandom);
        end
        send(1, 0, 1, $urandom);
        idle(4);

        chk("exp_queue_empty",  NB_DATA'(exp_q.size()), '0);
        chk("drop_queue_empty", NB_DATA'(drop_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
